// File: rtl/wb_arbiter_if.sv
// Signal bundle for wb_arbiter: both Wishbone master ports plus the shared slave port.
// Handshake: a master holds cyc for a whole bus cycle and raises stb per transfer; a transfer completes in the cycle where ack or err is high.
interface wb_arbiter_if;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic [31:0] m0_dat_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_cyc_i, m1_cyc_i;
  logic        m0_stb_i, m1_stb_i;
  logic        m0_we_i, m1_we_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_err_o, m1_err_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;

  // Arbiter side: it is the slave of both masters and drives the shared slave port.
  modport slave (
    input  m0_addr_i, m1_addr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    input  m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    output s_addr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o
  );

  // Environment side: the two masters and the BRAM.
  modport master (
    output m0_addr_i, m1_addr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    output m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    input  s_addr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one BRAM port,
// with a watchdog that ends a stalled transfer with an error.
module wb_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus,
  output logic [1:0]  o_dbg_state
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    TOERR = 2'd3
  } state_t;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic       r_last, w_last_nxt;
  logic [7:0] r_wd, w_wd_nxt;
  logic       w_sel1, w_cyc, w_stb, w_resp;

  // In TOERR the owner is still identified by r_last, which was set at grant.
  assign w_sel1 = (r_state == OWN1) || ((r_state == TOERR) && r_last);
  assign w_cyc  = w_sel1 ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign w_stb  = w_sel1 ? bus.m1_stb_i : bus.m0_stb_i;
  assign w_resp = bus.s_ack_i | bus.s_err_i;

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_wd    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_wd_nxt     = r_wd;
    bus.s_addr_o = 32'd0;
    bus.s_dat_o  = 32'd0;
    bus.s_sel_o  = 4'd0;
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.m0_ack_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_err_o = 1'b0;

    case (r_state)
      IDLE: begin
        w_wd_nxt = 8'd0;
        // On a tie the master that was not granted last wins.
        if (bus.m0_cyc_i && (!bus.m1_cyc_i || r_last)) begin
          w_state_nxt = OWN0;
          w_last_nxt  = 1'b0;
        end else if (bus.m1_cyc_i) begin
          w_state_nxt = OWN1;
          w_last_nxt  = 1'b1;
        end
      end

      OWN0, OWN1: begin
        bus.s_addr_o = w_sel1 ? bus.m1_addr_i : bus.m0_addr_i;
        bus.s_dat_o  = w_sel1 ? bus.m1_dat_i  : bus.m0_dat_i;
        bus.s_sel_o  = w_sel1 ? bus.m1_sel_i  : bus.m0_sel_i;
        bus.s_we_o   = w_sel1 ? bus.m1_we_i   : bus.m0_we_i;
        bus.s_cyc_o  = w_cyc;
        bus.s_stb_o  = w_stb;
        if (w_sel1) begin
          bus.m1_ack_o = bus.s_ack_i;
          bus.m1_err_o = bus.s_err_i;
        end else begin
          bus.m0_ack_o = bus.s_ack_i;
          bus.m0_err_o = bus.s_err_i;
        end

        if (w_resp) begin
          w_wd_nxt = 8'd0;
        end else if (w_stb) begin
          w_wd_nxt = r_wd + 8'd1;
        end

        // Dropping cyc takes priority over a watchdog expiry in the same cycle.
        if (!w_cyc) begin
          w_state_nxt = IDLE;
        end else if (w_stb && !w_resp && (r_wd == WD_LIMIT)) begin
          w_state_nxt = TOERR;
        end
      end

      TOERR: begin
        if (r_last) begin
          bus.m1_err_o = 1'b1;
        end else begin
          bus.m0_err_o = 1'b1;
        end
        w_wd_nxt    = 8'd0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: reset, a table of arbitration cycles, directed corner
// sequences, and randomized traffic checked against a transaction-level model.
module tb_wb_arbiter;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_OWN0 = 2'd1, ST_OWN1 = 2'd2, ST_TOERR = 2'd3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus();
  wb_arbiter_if bus1();
  logic [1:0] dbg, dbg1;

  wb_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg));
  wb_arbiter #(.TIMEOUT(1)) dut_t1 (.clk(clk), .rst(rst), .bus(bus1), .o_dbg_state(dbg1));

  // ---------------- slave model (BRAM) ----------------
  logic        auto_ack, man_ack, man_err;
  logic [31:0] mem [256];
  bit          mem_vld [256];

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    return (idx == 8'd4) ? 32'hDEAD_BEEF : {24'h5A5A5A, idx};
  endfunction

  assign bus.s_ack_i = auto_ack ? (bus.s_cyc_o & bus.s_stb_o) : man_ack;
  assign bus.s_err_i = auto_ack ? 1'b0 : man_err;
  assign bus.s_dat_i = mem_vld[bus.s_addr_o[9:2]] ? mem[bus.s_addr_o[9:2]] : init_word(bus.s_addr_o[9:2]);

  always @(posedge clk) begin
    if (bus.s_cyc_o && bus.s_stb_o && bus.s_we_o && bus.s_ack_i) begin
      mem[bus.s_addr_o[9:2]]     <= bus.s_dat_o;
      mem_vld[bus.s_addr_o[9:2]] <= 1'b1;
    end
  end

  assign bus1.s_ack_i = 1'b0;
  assign bus1.s_err_i = 1'b0;
  assign bus1.s_dat_i = 32'd0;

  // ---------------- master drivers ----------------
  bit          cyc [2], stb [2], we [2];
  logic [31:0] addr [2], dat [2];
  logic [3:0]  sel [2];

  task automatic drive();
    bus.m0_cyc_i = cyc[0]; bus.m0_stb_i = stb[0]; bus.m0_we_i = we[0];
    bus.m0_addr_i = addr[0]; bus.m0_dat_i = dat[0]; bus.m0_sel_i = sel[0];
    bus.m1_cyc_i = cyc[1]; bus.m1_stb_i = stb[1]; bus.m1_we_i = we[1];
    bus.m1_addr_i = addr[1]; bus.m1_dat_i = dat[1]; bus.m1_sel_i = sel[1];
  endtask

  task automatic set_m(input int m, input bit c, input bit s, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    cyc[m] = c; stb[m] = s; we[m] = w; addr[m] = a; dat[m] = d; sel[m] = 4'hF;
    drive();
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] resp_vec();
    return {bus.s_cyc_o, bus.s_stb_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o};
  endfunction

  // Row layout: c0 s0 c1 s1 ack err | s_cyc s_stb m0_ack m1_ack m0_err m1_err | state
  typedef struct packed {
    logic [5:0] in;
    logic [5:0] out;
    logic [1:0] st;
  } vec_t;
  vec_t tbl [15];

  // ---------------- reference model state ----------------
  int m_owner, m_last, m_wd;
  bit m_toerr;
  int ack_pct, err_pct;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    auto_ack = 1'b0; man_ack = 1'b0; man_err = 1'b0;
    idle_all();
    bus1.m0_cyc_i = 1'b0; bus1.m0_stb_i = 1'b0; bus1.m0_we_i = 1'b0;
    bus1.m0_addr_i = 32'd0; bus1.m0_dat_i = 32'd0; bus1.m0_sel_i = 4'd0;
    bus1.m1_cyc_i = 1'b0; bus1.m1_stb_i = 1'b0; bus1.m1_we_i = 1'b0;
    bus1.m1_addr_i = 32'd0; bus1.m1_dat_i = 32'd0; bus1.m1_sel_i = 4'd0;

    // ---- reset values ----
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp", 32'(resp_vec()), 32'd0);
    chk("rst_addr", bus.s_addr_o, 32'd0);
    chk("rst_state", 32'(dbg), 32'(ST_IDLE));
    @(negedge clk) rst = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("post_rst_state", 32'(dbg), 32'(ST_IDLE));
      chk("post_rst_resp", 32'(resp_vec()), 32'd0);
    end

    // ---- table: round-robin, grant hold, ack/err pass-through ----
    tbl[0]  = 14'b111100_000000_00;
    tbl[1]  = 14'b111110_111000_01;
    tbl[2]  = 14'b001100_000000_01;
    tbl[3]  = 14'b001100_000000_00;
    tbl[4]  = 14'b001110_110100_10;
    tbl[5]  = 14'b110000_000000_10;
    tbl[6]  = 14'b111100_000000_00;
    tbl[7]  = 14'b111101_110010_01;
    tbl[8]  = 14'b101100_100000_01;
    tbl[9]  = 14'b111111_111010_01;
    tbl[10] = 14'b001100_000000_01;
    tbl[11] = 14'b001100_000000_00;
    tbl[12] = 14'b001100_110000_10;
    tbl[13] = 14'b000000_000000_10;
    tbl[14] = 14'b000000_000000_00;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_m(0, tbl[i].in[5], tbl[i].in[4], 1'b0, 32'h100, 32'd0);
      set_m(1, tbl[i].in[3], tbl[i].in[2], 1'b0, 32'h200, 32'd0);
      man_ack = tbl[i].in[1];
      man_err = tbl[i].in[0];
      #1;
      chk($sformatf("tbl%0d_resp", i), 32'(resp_vec()), 32'(tbl[i].out));
      chk($sformatf("tbl%0d_state", i), 32'(dbg), 32'(tbl[i].st));
    end
    man_ack = 1'b0; man_err = 1'b0;

    // ---- single read on m0 with a zero-wait slave ----
    @(negedge clk);
    auto_ack = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    #1 chk("rd_req_cyc", 32'(bus.s_cyc_o), 32'd0);
    @(negedge clk); #1;
    chk("rd_cyc_stb", 32'({bus.s_cyc_o, bus.s_stb_o}), 32'd3);
    chk("rd_addr", bus.s_addr_o, 32'h10);
    chk("rd_m0_ack", 32'(bus.m0_ack_o), 32'd1);
    chk("rd_m0_dat", bus.m0_dat_o, 32'hDEAD_BEEF);
    chk("rd_m1_ack", 32'(bus.m1_ack_o), 32'd0);
    @(negedge clk);
    idle_all();
    #1 chk("rd_ack_end", 32'(bus.m0_ack_o), 32'd0);
    @(negedge clk); #1 chk("rd_back_idle", 32'(dbg), 32'(ST_IDLE));

    // ---- grant hold: m1 write then read under one cyc, m0 waiting ----
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);
    #1 chk("gh_req_cyc", 32'(bus.s_cyc_o), 32'd0);
    @(negedge clk); #1;
    chk("gh_wr_ctl", 32'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.m1_ack_o, bus.m0_ack_o}), 32'b11110);
    chk("gh_wr_addr", bus.s_addr_o, 32'h20);
    chk("gh_wr_dat", bus.s_dat_o, 32'hA5A5_A5A5);
    @(negedge clk);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
    #1 chk("gh_gap_ctl", 32'({bus.s_cyc_o, bus.s_stb_o, bus.m1_ack_o, bus.m0_ack_o}), 32'b1000);
    @(negedge clk);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
    #1;
    chk("gh_rd_ack", 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'b10);
    chk("gh_rd_dat", bus.m1_dat_o, 32'hA5A5_A5A5);
    @(negedge clk);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 chk("gh_drop_ctl", 32'({bus.s_cyc_o, bus.m0_ack_o}), 32'd0);
    @(negedge clk); #1;
    chk("gh_dead_state", 32'(dbg), 32'(ST_IDLE));
    chk("gh_dead_cyc", 32'(bus.s_cyc_o), 32'd0);
    @(negedge clk); #1;
    chk("gh_m0_grant", 32'({bus.s_cyc_o, bus.m0_ack_o}), 32'b11);
    chk("gh_m0_addr", bus.s_addr_o, 32'h40);
    chk("gh_m0_dat", bus.m0_dat_o, 32'h5A5A_5A10);
    @(negedge clk) idle_all();
    @(negedge clk);

    // ---- watchdog timeout on m0 with m1 pending ----
    auto_ack = 1'b0; man_ack = 1'b0; man_err = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h60, 32'd0);
    #1 chk("to_req_cyc", 32'(bus.s_cyc_o), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) set_m(1, 1'b1, 1'b1, 1'b0, 32'h300, 32'd0);
      #1;
      if (k < 17) begin
        chk($sformatf("to_wait%0d", k), 32'({bus.s_cyc_o, bus.m0_err_o, bus.m1_err_o}), 32'b100);
      end else begin
        chk("to_fire_resp", 32'(resp_vec()), 32'b000010);
        chk("to_fire_state", 32'(dbg), 32'(ST_TOERR));
      end
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 chk("to_idle", 32'({dbg, bus.s_cyc_o, bus.m0_err_o}), 32'd0);
    @(negedge clk); #1;
    chk("to_m1_state", 32'(dbg), 32'(ST_OWN1));
    chk("to_m1_addr", bus.s_addr_o, 32'h300);
    @(negedge clk) idle_all();
    @(negedge clk);

    // ---- slave error keeps ownership, then async reset mid-transfer ----
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h304, 32'd0);
    #1 chk("er_req_cyc", 32'(bus.s_cyc_o), 32'd0);
    @(negedge clk);
    man_err = 1'b1;
    #1 chk("er_pulse", 32'(resp_vec()), 32'b110001);
    @(negedge clk);
    man_err = 1'b0;
    #1;
    chk("er_after", 32'(resp_vec()), 32'b110000);
    chk("er_keep_state", 32'(dbg), 32'(ST_OWN1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_resp", 32'(resp_vec()), 32'd0);
    chk("ar_state", 32'(dbg), 32'(ST_IDLE));
    @(negedge clk) idle_all();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'd0);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h48, 32'd0);
    #1 chk("ar_rearb_idle", 32'(dbg), 32'(ST_IDLE));
    @(negedge clk); #1;
    chk("ar_rearb_state", 32'(dbg), 32'(ST_OWN0));
    chk("ar_rearb_addr", bus.s_addr_o, 32'h44);
    @(negedge clk) idle_all();
    @(negedge clk);

    // ---- TIMEOUT=1 instance: immediate error, and cyc drop beats the timeout ----
    bus1.m0_cyc_i = 1'b1; bus1.m0_stb_i = 1'b1; bus1.m0_addr_i = 32'h80;
    #1 chk("t1_req", 32'(bus1.s_cyc_o), 32'd0);
    @(negedge clk); #1 chk("t1_own", 32'({bus1.s_cyc_o, bus1.m0_err_o}), 32'b10);
    @(negedge clk); #1;
    chk("t1_err", 32'({bus1.s_cyc_o, bus1.s_stb_o, bus1.m0_err_o, bus1.m1_err_o}), 32'b0010);
    chk("t1_err_state", 32'(dbg1), 32'(ST_TOERR));
    @(negedge clk); #1 chk("t1_idle", 32'({dbg1, bus1.m0_err_o}), 32'd0);
    @(negedge clk);
    bus1.m0_cyc_i = 1'b0;
    #1;
    chk("t1_drop_state", 32'(dbg1), 32'(ST_OWN0));
    chk("t1_drop_ctl", 32'({bus1.s_cyc_o, bus1.s_stb_o, bus1.m0_err_o}), 32'b010);
    @(negedge clk);
    bus1.m0_stb_i = 1'b0;
    #1 chk("t1_drop_wins", 32'({dbg1, bus1.m0_err_o}), 32'd0);

    // ---- randomized traffic against the transaction-level model ----
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    m_owner = -1; m_last = 1; m_wd = 0; m_toerr = 1'b0;
    ack_pct = 50; err_pct = 5;
    for (int n = 0; n < 2000; n++) begin
      logic [6:0]  e_ctl;
      logic [31:0] e_addr, e_dat;
      logic [3:0]  e_sel;
      @(negedge clk);
      if (n % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 0;
          1: ack_pct = 10;
          2: ack_pct = 50;
          default: ack_pct = 90;
        endcase
        err_pct = (ack_pct == 0) ? 0 : 5;
      end
      for (int m = 0; m < 2; m++) begin
        if (cyc[m]) begin
          if ($urandom_range(0, 31) == 0) cyc[m] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          cyc[m] = 1'b1;
        end
        stb[m]  = cyc[m] && ($urandom_range(0, 3) != 0);
        we[m]   = 1'($urandom_range(0, 1));
        addr[m] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        dat[m]  = $urandom;
        sel[m]  = 4'($urandom_range(0, 15));
      end
      man_ack = ($urandom_range(0, 99) < ack_pct);
      man_err = ($urandom_range(0, 99) < err_pct);
      drive();
      #1;
      e_ctl = 7'd0; e_addr = 32'd0; e_dat = 32'd0; e_sel = 4'd0;
      if (m_toerr) begin
        e_ctl = (m_owner == 0) ? 7'b0000010 : 7'b0000001;
      end else if (m_owner >= 0) begin
        e_ctl[6] = cyc[m_owner];
        e_ctl[5] = stb[m_owner];
        e_ctl[4] = we[m_owner];
        if (m_owner == 0) begin
          e_ctl[3] = man_ack; e_ctl[1] = man_err;
        end else begin
          e_ctl[2] = man_ack; e_ctl[0] = man_err;
        end
        e_addr = addr[m_owner];
        e_dat  = dat[m_owner];
        e_sel  = sel[m_owner];
      end
      chk($sformatf("rnd%0d_ctl", n), 32'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.m0_ack_o,
          bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}), 32'(e_ctl));
      chk($sformatf("rnd%0d_addr", n), bus.s_addr_o, e_addr);
      chk($sformatf("rnd%0d_wdat", n), bus.s_dat_o, e_dat);
      chk($sformatf("rnd%0d_sel", n), 32'(bus.s_sel_o), 32'(e_sel));
      chk($sformatf("rnd%0d_rdat", n), bus.m1_dat_o, bus.s_dat_i);
      @(posedge clk);
      if (m_toerr) begin
        m_toerr = 1'b0;
        m_owner = -1;
      end else if (m_owner < 0) begin
        if (cyc[0] && cyc[1]) m_owner = 1 - m_last;
        else if (cyc[0])      m_owner = 0;
        else if (cyc[1])      m_owner = 1;
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_wd   = 0;
        end
      end else if (!cyc[m_owner]) begin
        m_owner = -1;
      end else if (stb[m_owner] && !man_ack && !man_err && (m_wd == TO - 1)) begin
        m_toerr = 1'b1;
      end else if (man_ack || man_err) begin
        m_wd = 0;
      end else if (stb[m_owner]) begin
        m_wd = m_wd + 1;
      end
    end

    @(negedge clk) idle_all();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master, one-slave Wishbone arbiter that shares the single BRAM port between the instruction-fetch master (port m0, fed by `load_store_unit` `i*` signals) and a data master (port m1). It sits between the masters and `bram`. It grants the bus round-robin per bus cycle and holds the grant for the whole cycle while the owner keeps `cyc` high. A bus watchdog ends a transfer with an error if the slave stalls.

## Interface

Parameters:
- `TIMEOUT`, default 16: cycles with slave strobe asserted and no `ack`/`err` before a forced error. Legal range 1..255.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `m0_addr_i`, `m1_addr_i`  in  32  master address
- `m0_dat_i`, `m1_dat_i`  in  32  master write data
- `m0_sel_i`, `m1_sel_i`  in  4  byte selects
- `m0_cyc_i`, `m1_cyc_i`  in  1  bus-cycle request/hold
- `m0_stb_i`, `m1_stb_i`  in  1  transfer strobe
- `m0_we_i`, `m1_we_i`  in  1  write enable
- `m0_dat_o`, `m1_dat_o`  out  32  read data, both equal to `s_dat_i`
- `m0_ack_o`, `m1_ack_o`  out  1  acknowledge, owner only
- `m0_err_o`, `m1_err_o`  out  1  error, owner only
- `s_addr_o`  out  32  slave address
- `s_dat_o`  out  32  slave write data
- `s_sel_o`  out  4  slave byte selects
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave controls
- `s_dat_i`  in  32  slave read data
- `s_ack_i`, `s_err_i`  in  1  slave acknowledge and error

## Operation

Registered state:
- `state` ∈ {IDLE, OWN0, OWN1, TOERR}
- `last`: the last granted master; reset value 1, so m0 wins first.
- `wd`: 8-bit watchdog counter.

Transitions:
- **IDLE**
  - Only m0_cyc → OWN0.
  - Only m1_cyc → OWN1.
  - Both → the master ≠ `last`.
  - Neither → stay.
  - On grant, `last` is updated to the granted master.
- **OWNx**
  - Slave outputs mirror master x combinationally.
  - `mx_ack_o = s_ack_i` and `mx_err_o = s_err_i`.
  - The other master sees ack=0 and err=0.
  - Owner drops cyc → IDLE.
  - `wd` reaches TIMEOUT−1 with stb high and no ack/err → TOERR.
- **TOERR** (one cycle)
  - `s_cyc_o` and `s_stb_o` are 0.
  - `mx_err_o = 1` for owner x.
  - Next state: IDLE.

Watchdog:
- `wd` clears on entering OWNx and on every cycle with `s_ack_i | s_err_i`.
- It increments while in OWNx with `s_stb_o=1`.
- It holds while stb is low.

Other rules:
- In IDLE and TOERR, all slave outputs are 0, except `s_dat_o`/`s_addr_o`, which are don't-care and driven 0.
- An owner may run multiple stb transfers under one cyc; the grant is not re-arbitrated between them.
- The owner's `ack`/`err` is combinational from the slave; the arbiter adds no registers on the response path.
- Slave `ack` and `err` in the same cycle: both are passed through; `wd` clears.

## Timing

Reset (asynchronous assertion, any time including mid-transfer):
- `state`=IDLE, `last`=1, `wd`=0.
- All `s_*_o`=0 and all `m*_ack_o`/`m*_err_o`=0 immediately.
- Release is synchronous to `clk`.

Latencies:
- Arbitration: cyc seen in IDLE at edge N → slave driven in cycle N+1.
- Minimum transfer with a zero-wait slave: 2 cycles from request to ack.
- Release: the owner drops cyc at edge N → IDLE at N+1. The other master can be granted at N+2, which leaves one dead cycle.

Edge cases:
- Owner drops cyc in the same cycle as the timeout would fire: the drop wins, with no error.
- `TIMEOUT=1`: the error fires after the first unacknowledged stb cycle.
- Requests from the non-owner are ignored until IDLE; its outputs stay 0.

## Test plan

1. **Reset values:** assert `rst` → all `s_*` outputs and all `m*_ack`/`m*_err` read 0; release with no requests → state stays IDLE.
2. **Single read on m0:** m0 reads `0x0000_0010` with `bram` word `0xDEADBEEF` → `s_cyc`/`s_stb` high the cycle after the request with `s_addr_o=0x10`; `m0_ack_o` pulses one cycle with `m0_dat_o=0xDEADBEEF`; `m1_ack_o` stays 0.
3. **Round-robin:** m0 and m1 raise cyc together after reset → m0 is served first and m1 next, each with a one-cycle IDLE gap; both again → m0 first, because `last`=1.
4. **Grant hold:** m1 writes `0xA5A5A5A5` to `0x20`, then reads `0x20` within one cyc while m0 requests → m1 completes both transfers and reads back `0xA5A5A5A5`; m0 is granted only after m1 drops cyc.
5. **Timeout:** TIMEOUT=16, slave holds ack=0 on an m0 strobe → `m0_err_o` pulses exactly at the 17th cycle after grant, with `s_cyc_o`=0 that cycle; a pending m1 is then granted.
6. **Error and reset mid-transfer:** slave returns `s_err_i` → `m1_err_o` pulses and m1 keeps ownership. Then assert `rst` mid-transfer → `s_cyc_o` falls without waiting for a clock edge, and the next arbitration grants m0 first.
